// File: rtl/jtkicker_romarb_pkg.sv
// Shared definitions for the four-slot ROM arbiter: FSM encoding, slot count and miss priority.
package jtkicker_romarb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int NSLOTS = 4;

    // Entry 0 is the highest priority: slot3 > slot2 > slot0 > slot1
    localparam logic [NSLOTS-1:0][1:0] SLOT_PRIO = {2'd1, 2'd0, 2'd2, 2'd3};

    function automatic logic [1:0] pick_slot(input logic [NSLOTS-1:0] miss);
        pick_slot = SLOT_PRIO[0];
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (miss[SLOT_PRIO[i]]) pick_slot = SLOT_PRIO[i];
        end
    endfunction

endpackage

// File: rtl/jtkicker_romarb_line.sv
// One-word cache line for a single ROM slot; reports a hit for the current word address.
module jtkicker_romarb_line (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        cs,
    input  logic [21:0] word_addr,
    input  logic        fill,
    input  logic [21:0] fill_addr,
    input  logic [15:0] fill_data,
    output logic        ok,
    output logic [15:0] data
);

    logic        valid;
    logic [21:0] addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            addr  <= fill_addr;
            data  <= fill_data;
        end
    end

    assign ok = cs & valid & (addr == word_addr);

endmodule

// File: rtl/jtkicker_romarb.sv
// Four-slot ROM arbiter: each slot caches one SDRAM word, misses are served one at a time.
module jtkicker_romarb
    import jtkicker_romarb_pkg::*;
#(
    parameter int          SLOT0_AW     = 13,
    parameter int          SLOT1_AW     = 14,
    parameter int          SLOT2_AW     = 14,
    parameter int          SLOT3_AW     = 16,
    parameter logic [21:0] SLOT0_OFFSET = 22'd0,
    parameter logic [21:0] SLOT1_OFFSET = 22'd0,
    parameter logic [21:0] SLOT2_OFFSET = 22'd0,
    parameter logic [21:0] SLOT3_OFFSET = 22'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                slot0_cs,
    input  logic                slot1_cs,
    input  logic                slot2_cs,
    input  logic                slot3_cs,
    input  logic [SLOT0_AW-1:0] slot0_addr,
    input  logic [SLOT1_AW-1:0] slot1_addr,
    input  logic [SLOT2_AW-1:0] slot2_addr,
    input  logic [SLOT3_AW-1:0] slot3_addr,
    output logic                slot0_ok,
    output logic                slot1_ok,
    output logic                slot2_ok,
    output logic                slot3_ok,
    output logic [15:0]         slot0_dout,
    output logic [15:0]         slot1_dout,
    output logic [7:0]          slot2_dout,
    output logic [7:0]          slot3_dout,
    input  logic                downloading,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic                data_dst,
    input  logic                data_rdy,
    output logic [21:0]         sdram_addr,
    input  logic [15:0]         data_read
);

    state_t                    state, state_nx;
    logic [NSLOTS-1:0][21:0]   wa;
    logic [NSLOTS-1:0][15:0]   line_data;
    logic [NSLOTS-1:0]         cs, ok, miss, fill;
    logic [1:0]                win, winner;

    // Byte-addressed slots drop addr[0]; it only selects the byte on the way out
    always_comb begin
        wa[0] = SLOT0_OFFSET + 22'(slot0_addr);
        wa[1] = SLOT1_OFFSET + 22'(slot1_addr);
        wa[2] = SLOT2_OFFSET + 22'(slot2_addr[SLOT2_AW-1:1]);
        wa[3] = SLOT3_OFFSET + 22'(slot3_addr[SLOT3_AW-1:1]);
    end

    assign cs   = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
    assign miss = cs & ~ok;
    assign win  = pick_slot(miss);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|miss)     state_nx = REQ;
            REQ:     if (sdram_ack) state_nx = WAIT;
            WAIT:    if (data_rdy)  state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
        if (downloading) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Winner and address stay latched so a slot changing mid-request cannot disturb the fill
    always_ff @(posedge clk) begin
        if (rst) begin
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            winner     <= '0;
        end else if (downloading) begin
            sdram_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|miss) begin
                    winner     <= win;
                    sdram_addr <= wa[win];
                    sdram_req  <= 1'b1;
                end
                REQ:  if (sdram_ack) sdram_req <= 1'b0;
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NSLOTS; i++) begin : g_line
        assign fill[i] = (state == WAIT) & data_rdy & ~downloading & (winner == 2'(i));

        jtkicker_romarb_line u_line (
            .clk       (clk),
            .rst       (rst),
            .clr       (downloading),
            .cs        (cs[i]),
            .word_addr (wa[i]),
            .fill      (fill[i]),
            .fill_addr (sdram_addr),
            .fill_data (data_read),
            .ok        (ok[i]),
            .data      (line_data[i])
        );
    end

    assign slot0_ok   = ok[0];
    assign slot1_ok   = ok[1];
    assign slot2_ok   = ok[2];
    assign slot3_ok   = ok[3];
    assign slot0_dout = line_data[0];
    assign slot1_dout = line_data[1];
    assign slot2_dout = slot2_addr[0] ? line_data[2][15:8] : line_data[2][7:0];
    assign slot3_dout = slot3_addr[0] ? line_data[3][15:8] : line_data[3][7:0];

endmodule

// File: tb/tb_jtkicker_romarb.sv
// Directed bench for jtkicker_romarb: request addresses checked by a scoreboard monitor, slot outputs checked inline.
module tb_jtkicker_romarb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slot0_cs = 0, slot1_cs = 0, slot2_cs = 0, slot3_cs = 0;
    logic [12:0] slot0_addr = '0;
    logic [13:0] slot1_addr = '0;
    logic [13:0] slot2_addr = '0;
    logic [15:0] slot3_addr = '0;
    logic        slot0_ok, slot1_ok, slot2_ok, slot3_ok;
    logic [15:0] slot0_dout, slot1_dout;
    logic [7:0]  slot2_dout, slot3_dout;
    logic        downloading = 0, sdram_ack = 0, data_dst = 0, data_rdy = 0;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic [15:0] data_read = '0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [21:0] exp_q[$];
    logic        prev_req = 1'b0;

    jtkicker_romarb #(
        .SLOT0_AW(13), .SLOT1_AW(14), .SLOT2_AW(14), .SLOT3_AW(16),
        .SLOT0_OFFSET(22'd0), .SLOT1_OFFSET(22'h8000),
        .SLOT2_OFFSET(22'd0), .SLOT3_OFFSET(22'd0)
    ) dut (
        .clk(clk), .rst(rst),
        .slot0_cs(slot0_cs), .slot1_cs(slot1_cs), .slot2_cs(slot2_cs), .slot3_cs(slot3_cs),
        .slot0_addr(slot0_addr), .slot1_addr(slot1_addr),
        .slot2_addr(slot2_addr), .slot3_addr(slot3_addr),
        .slot0_ok(slot0_ok), .slot1_ok(slot1_ok), .slot2_ok(slot2_ok), .slot3_ok(slot3_ok),
        .slot0_dout(slot0_dout), .slot1_dout(slot1_dout),
        .slot2_dout(slot2_dout), .slot3_dout(slot3_dout),
        .downloading(downloading), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .data_dst(data_dst), .data_rdy(data_rdy), .sdram_addr(sdram_addr),
        .data_read(data_read)
    );

    always #5 clk = ~clk;

    // Every new SDRAM request must match the next address the stimulus announced
    always @(negedge clk) begin
        if (sdram_req && !prev_req) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_req: got addr %h, expected no request", sdram_addr);
            end else begin
                logic [21:0] e;
                e = exp_q.pop_front();
                if (sdram_addr !== e) begin
                    n_bad++;
                    $display("FAIL req_addr: got %h expected %h", sdram_addr, e);
                end
            end
        end
        prev_req = sdram_req;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all_ok_low(input string nm);
        check({nm, "_ok0"}, 32'(slot0_ok), 0);
        check({nm, "_ok1"}, 32'(slot1_ok), 0);
        check({nm, "_ok2"}, 32'(slot2_ok), 0);
        check({nm, "_ok3"}, 32'(slot3_ok), 0);
    endtask

    // Minimal SDRAM: wait for req, ack after a couple of cycles, then return data
    task automatic serve(input logic [15:0] d);
        int n = 0;
        while (!sdram_req && n < 20) begin
            tick;
            n++;
        end
        check("req_seen", 32'(sdram_req), 1);
        tick;
        tick;
        check("req_held", 32'(sdram_req), 1);
        sdram_ack = 1;
        tick;
        sdram_ack = 0;
        check("req_drop", 32'(sdram_req), 0);
        data_dst = 1;
        tick;
        data_dst  = 0;
        data_read = d;
        data_rdy  = 1;
        tick;
        data_rdy  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        slot3_cs = 1;
        slot3_addr = 16'h1235;
        tick;
        tick;
        check("rst_req", 32'(sdram_req), 0);
        check("rst_addr", 32'(sdram_addr), 0);
        check_all_ok_low("rst");
        slot3_cs = 0;
        rst = 0;
        tick;

        // Single miss on slot3, high byte returned
        exp_q.push_back(22'h091A);
        slot3_cs = 1;
        tick;
        check("miss_req_next", 32'(sdram_req), 1);
        check("miss_addr", 32'(sdram_addr), 32'h091A);
        serve(16'hBEEF);
        check("fill_ok3", 32'(slot3_ok), 1);
        check("fill_dout3", 32'(slot3_dout), 32'hBE);

        // Hit on the other byte of the same word, no new request
        slot3_addr = 16'h1234;
        #1;
        check("hit_ok3", 32'(slot3_ok), 1);
        check("hit_dout3", 32'(slot3_dout), 32'hEF);
        tick; tick; tick;
        check("hit_no_req", 32'(sdram_req), 0);

        // Simultaneous misses: served 3, 0, 1; slot1 carries its 0x8000 offset
        exp_q.push_back(22'h1000);
        exp_q.push_back(22'h0040);
        exp_q.push_back(22'h8010);
        slot3_addr = 16'h2000;
        slot0_cs = 1; slot0_addr = 13'h0040;
        slot1_cs = 1; slot1_addr = 14'h0010;
        serve(16'hA55A);
        check("pri1_ok3", 32'(slot3_ok), 1);
        check("pri1_dout3", 32'(slot3_dout), 32'h5A);
        check("pri1_ok0", 32'(slot0_ok), 0);
        check("pri1_ok1", 32'(slot1_ok), 0);
        serve(16'h1234);
        check("pri2_ok0", 32'(slot0_ok), 1);
        check("pri2_dout0", 32'(slot0_dout), 32'h1234);
        check("pri2_ok1", 32'(slot1_ok), 0);
        serve(16'hCAFE);
        check("pri3_ok1", 32'(slot1_ok), 1);
        check("pri3_dout1", 32'(slot1_dout), 32'hCAFE);

        // Stray ack / data_rdy while idle change nothing
        sdram_ack = 1;
        tick;
        sdram_ack = 0;
        data_read = 16'hDEAD;
        data_rdy  = 1;
        tick;
        data_rdy  = 0;
        tick;
        check("stray_dout1", 32'(slot1_dout), 32'hCAFE);
        check("stray_dout0", 32'(slot0_dout), 32'h1234);
        check("stray_req", 32'(sdram_req), 0);

        // Slot changes mid-request: the fill still lands at the requested word
        exp_q.push_back(22'h0080);
        slot2_cs = 1; slot2_addr = 14'h0101;
        tick;
        slot2_cs = 0; slot2_addr = 14'h0300;
        serve(16'h7788);
        slot2_addr = 14'h0101; slot2_cs = 1;
        #1;
        check("midreq_ok2", 32'(slot2_ok), 1);
        check("midreq_dout2", 32'(slot2_dout), 32'h77);

        // Download abort while waiting for data
        exp_q.push_back(22'h0200);
        slot2_addr = 14'h0400;
        tick;
        check("abort_req_up", 32'(sdram_req), 1);
        sdram_ack = 1;
        tick;
        sdram_ack = 0;
        downloading = 1;
        tick;
        check("abort_req", 32'(sdram_req), 0);
        check_all_ok_low("abort");
        data_read = 16'hFFFF;
        data_rdy  = 1;
        tick;
        data_rdy  = 0;
        slot0_cs = 0; slot1_cs = 0; slot2_cs = 0; slot3_cs = 0;
        downloading = 0;
        tick;
        data_rdy = 1;
        tick;
        data_rdy = 0;
        slot2_cs = 1;
        #1;
        check("abort_nofill_ok2", 32'(slot2_ok), 0);
        exp_q.push_back(22'h0200);
        serve(16'h1357);
        check("refill_ok2", 32'(slot2_ok), 1);
        check("refill_dout2", 32'(slot2_dout), 32'h57);
        slot2_cs = 0;

        // Reset in the middle of a request
        exp_q.push_back(22'h0055);
        slot0_cs = 1; slot0_addr = 13'h0055;
        tick;
        check("rstmid_req_up", 32'(sdram_req), 1);
        rst = 1;
        tick;
        check("rstmid_req", 32'(sdram_req), 0);
        check("rstmid_addr", 32'(sdram_addr), 0);
        check_all_ok_low("rstmid");
        rst = 0;
        slot0_cs = 0;
        tick;
        data_read = 16'h4242;
        data_rdy  = 1;
        tick;
        data_rdy  = 0;
        slot0_cs = 1;
        #1;
        check("rstmid_nofill_ok0", 32'(slot0_ok), 0);
        slot0_cs = 0;
        tick; tick;
        check("rstmid_idle_req", 32'(sdram_req), 0);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtkicker_romarb.md
JTKICKER_ROMARB -- requirements
Module: jtkicker_romarb

Interface
REQ-001 SHALL have parameter SLOT0_AW, default 13, meaning slot 0 word-address width.
REQ-002 SHALL have parameter SLOT1_AW, default 14, meaning slot 1 word-address width.
REQ-003 SHALL have parameter SLOT2_AW, default 14, meaning slot 2 byte-address width.
REQ-004 SHALL have parameter SLOT3_AW, default 16, meaning slot 3 byte-address width.
REQ-005 SHALL have parameters SLOT0_OFFSET..SLOT3_OFFSET, 22 bits each, default 0, meaning the SDRAM word offset of each slot.
REQ-006 SHALL have ports: clk in 1, the single clock; rst in 1, reset, synchronous and active-high.
REQ-007 SHALL have ports: slotN_cs in 1; slotN_addr in SLOTN_AW; slotN_ok out 1 (N=0..3).
REQ-008 SHALL have ports: slot0_dout and slot1_dout out 16; slot2_dout and slot3_dout out 8.
REQ-009 SHALL have ports: downloading in 1; sdram_req out 1; sdram_ack in 1; data_dst in 1; data_rdy in 1; sdram_addr out 22; data_read in 16.

Function
REQ-010 SHALL keep one cache line per slot: valid bit, SDRAM word address and 16-bit data.
REQ-011 SHALL form the word address as offset+addr for slots 0/1, and offset+addr[AW-1:1] for slots 2/3.
REQ-012 SHALL drive slotN_ok = slotN_cs & valid & (cached word address == current word address), from registered state only.
REQ-013 SHALL drive slot2/3_dout from the cached high byte when addr[0]=1 and the low byte when addr[0]=0; slot0/1_dout SHALL be the cached word.
REQ-014 SHALL treat a slot as missing when cs=1 and ok=0.
REQ-015 SHALL arbitrate misses in fixed priority slot3 > slot2 > slot0 > slot1.
REQ-016 SHALL implement FSM IDLE -> REQ -> WAIT -> IDLE.
REQ-017 In IDLE with any miss, SHALL latch the winner and its word address, set sdram_req on the next edge, and go to REQ.
REQ-018 In REQ, SHALL hold sdram_req and sdram_addr stable until sdram_ack=1, then clear sdram_req and go to WAIT.
REQ-019 In WAIT, SHALL ignore data_dst and, on data_rdy=1, write data_read and the address to the winner's line, set valid, and return to IDLE.
REQ-020 Latency: miss sampled at edge N SHALL give sdram_req=1 after N; data_rdy at edge M SHALL give slot ok=1 after M.
REQ-021 A miss SHALL NOT be arbitrated in the same cycle as a line fill; the earliest new request follows the IDLE cycle.
REQ-022 If the winner's cs drops or its address changes mid-request, the transaction SHALL complete and fill the line with the requested address.
REQ-023 Exactly one SDRAM transaction SHALL be outstanding at any time.
REQ-024 While downloading=1, SHALL clear all valid bits, hold sdram_req=0, and force the FSM to IDLE, aborting any transaction.
REQ-025 sdram_ack or data_rdy outside REQ/WAIT respectively SHALL be ignored.

Reset
REQ-026 On rst=1 at a clk edge, SHALL set FSM=IDLE, sdram_req=0, sdram_addr=0, all valid=0 and all cached data=0; all slotN_ok SHALL then be 0.
REQ-027 Reset asserted mid-transaction SHALL abort it; a late data_rdy SHALL NOT fill any line.

Structure
REQ-028 Package jtkicker_romarb_pkg SHALL hold the FSM state encoding (IDLE, REQ, WAIT), the slot count (4) and the slot priority order.
REQ-029 SHALL instantiate sub-module jtkicker_romarb_line four times; each instance holds valid, address and data and computes its hit.

Verification
REQ-030 Single miss: slot3_cs=1, addr=0x1235, SLOT3_OFFSET=0 -> sdram_req next cycle, sdram_addr=0x091A; data_rdy with 0xBEEF -> slot3_ok=1, dout=0xBE.
REQ-031 Hit reuse: after REQ-030, addr=0x1234 -> slot3_ok=1 immediately, dout=0xEF, no sdram_req.
REQ-032 Priority: slot0, slot1 and slot3 miss in the same cycle -> service order 3, 0, 1, with three separate transactions.
REQ-033 Offset: SLOT1_OFFSET=0x8000, slot1_addr=0x0010 -> sdram_addr=0x8010.
REQ-034 Abort: downloading=1 while in WAIT -> sdram_req=0 and all ok=0; a later data_rdy fills nothing.
REQ-035 Reset mid-REQ: rst=1 with sdram_req=1 -> sdram_req=0 next cycle, all ok=0.
